sd_scoreboard_rmw: RTL and testbench
====================================

// Module: sd_scoreboard_rmw
// PURPOSE
//  Initiator for the sd_scoreboard request/response interface. Accepts atomic update
//  commands (add, set-bits, clear-bits, read) and performs each one in order: read,
//  compute, then an optional write. Only one transaction is in flight at a time.
//  Returns {itemid, old, new} per command. Sits between client logic and the scoreboard.
// PARAMETERS
//  width    8  scoreboard record width
//  asz      6  item address width
//  txid_sz  2  transaction-id width; the id counter wraps at 2**txid_sz
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-low reset
//  c_srdy       in   1        command valid
//  c_drdy       out  1        command accept
//  c_op         in   2        0=READ 1=ADD 2=SETB 3=CLRB
//  c_itemid     in   asz      target item
//  c_operand    in   width    add value or bit mask
//  sb_srdy      out  1        request valid to scoreboard
//  sb_drdy      in   1        scoreboard request accept
//  sb_req_type  out  1        0=read, 1=write
//  sb_txid      out  txid_sz  request transaction id
//  sb_itemid    out  asz      request item
//  sb_mask      out  width    write mask (1=update bit)
//  sb_data      out  width    write data
//  sbr_srdy     in   1        scoreboard response valid
//  sbr_drdy     out  1        response accept, tied 1
//  sbr_txid     in   txid_sz  response transaction id
//  sbr_data     in   width    read data
//  p_srdy       out  1        result valid
//  p_drdy       in   1        result accept
//  p_itemid     out  asz      result item
//  p_old        out  width    value before update
//  p_new        out  width    value after update (equals p_old for READ)
//  err_txid     out  1        one-cycle pulse on an unexpected or mismatched response
// BEHAVIOUR
//  - Reset: state=IDLE, txid counter=0. All registered outputs are 0. c_drdy=1 after reset.
//  - All sb_*, p_* and err_txid outputs are registered. A transfer occurs when srdy&drdy.
//  - IDLE: c_drdy=1. On c_srdy, latch op/itemid/operand -> RDREQ.
//  - RDREQ: sb_srdy=1, req_type=0, sb_txid=cur_txid. On sb_drdy -> RDWAIT;
//    cur_txid increments (mod 2**txid_sz, 3 wraps to 0 when txid_sz=2).
//  - RDWAIT: on sbr_srdy with sbr_txid==issued id, capture old=sbr_data and compute new.
//    Next state is RESULT if op=READ, otherwise WRREQ.
//  - WRREQ: sb_srdy=1, req_type=1, same itemid, sb_data=new, and
//    sb_mask = all ones (ADD) | operand (SETB, CLRB). On sb_drdy -> RESULT.
//  - RESULT: p_srdy=1. On p_drdy -> IDLE.
//  - Update rules:
//    ADD: new = old + operand, modulo 2**width, carry discarded.
//    SETB: new = old | operand. CLRB: new = old & ~operand.
//  - A response with a mismatched txid in RDWAIT, or any response in another state,
//    is accepted and dropped. It pulses err_txid and does not change state.
//  - sb_srdy and p_srdy hold stable until accepted. Outputs do not change while
//    srdy=1 and drdy=0.
//  - Minimum latency, from command accept to p_srdy, with drdy=1 and a 1-cycle
//    scoreboard response: 4 cycles for READ, 5 cycles for the others.
//  - Asynchronous reset mid-transaction aborts it: outputs go to 0 immediately
//    and no write is issued.
// STRUCTURE
//  - Shared include sd_scoreboard_defs.vh holds the op encodings (READ/ADD/SETB/CLRB),
//    the req_type encodings and the FSM state encodings.
//  - One sub-module, sd_scoreboard_rmw_alu: combinational (op, old, operand) -> (new, mask).
// TESTING
//  1 READ item 5, model returns 0x3C with txid 0 -> no write; p={5,0x3C,0x3C}; next txid=1.
//  2 ADD item 2 operand 0x05 on 0xFE -> write data 0x03, mask 0xFF; p_old=0xFE, p_new=0x03.
//  3 SETB 0x0F on 0xA0, then CLRB 0x81 on 0xAF -> writes 0xAF/mask 0x0F, then 0x2E/mask 0x81.
//  4 Mismatched txid=3 in RDWAIT, then the correct txid -> one err_txid pulse;
//    the transaction completes normally.
//  5 Backpressure: hold sb_drdy=0 and p_drdy=0 for 10 cycles -> outputs stable;
//    c_drdy=0 until the RESULT handshake. After 5 commands the txid wraps 3->0.
//  6 Assert reset during WRREQ -> sb_srdy=0 at once, state IDLE, txid=0, no write observed.

Source files
------------

// File: rtl/sd_scoreboard_rmw_pkg.sv
// Shared encodings for the scoreboard read-modify-write initiator.
`default_nettype none

package sd_scoreboard_rmw_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_ADD  = 2'd1,
    OP_SETB = 2'd2,
    OP_CLRB = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RDREQ  = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_WRREQ  = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sd_scoreboard_rmw_alu.sv
// Update datapath: derives the new record value and the write mask from op and old value.
`default_nettype none

module sd_scoreboard_rmw_alu
  import sd_scoreboard_rmw_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] new_o,
  output logic [WIDTH-1:0] mask_o
);

  always_comb begin
    new_o  = old_i;
    mask_o = '0;
    case (op_e'(op_i))
      OP_ADD: begin
        // Carry out of the top bit is intentionally discarded.
        new_o  = old_i + operand_i;
        mask_o = '1;
      end
      OP_SETB: begin
        new_o  = old_i | operand_i;
        mask_o = operand_i;
      end
      OP_CLRB: begin
        new_o  = old_i & ~operand_i;
        mask_o = operand_i;
      end
      default: begin
        new_o  = old_i;
        mask_o = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sd_scoreboard_rmw.sv
// Single-outstanding read-modify-write initiator in front of the sd_scoreboard.
`default_nettype none

module sd_scoreboard_rmw
  import sd_scoreboard_rmw_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ASZ     = 6,
  parameter int TXID_SZ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_srdy_i,
  output logic               c_drdy_o,
  input  logic [1:0]         c_op_i,
  input  logic [ASZ-1:0]     c_itemid_i,
  input  logic [WIDTH-1:0]   c_operand_i,
  output logic               sb_srdy_o,
  input  logic               sb_drdy_i,
  output logic               sb_req_type_o,
  output logic [TXID_SZ-1:0] sb_txid_o,
  output logic [ASZ-1:0]     sb_itemid_o,
  output logic [WIDTH-1:0]   sb_mask_o,
  output logic [WIDTH-1:0]   sb_data_o,
  input  logic               sbr_srdy_i,
  output logic               sbr_drdy_o,
  input  logic [TXID_SZ-1:0] sbr_txid_i,
  input  logic [WIDTH-1:0]   sbr_data_i,
  output logic               p_srdy_o,
  input  logic               p_drdy_i,
  output logic [ASZ-1:0]     p_itemid_o,
  output logic [WIDTH-1:0]   p_old_o,
  output logic [WIDTH-1:0]   p_new_o,
  output logic               err_txid_o
);

  state_e               state_q, state_d;
  logic [TXID_SZ-1:0]   cur_txid_q, cur_txid_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic                 sb_srdy_q, sb_srdy_d;
  logic                 sb_req_type_q, sb_req_type_d;
  logic [TXID_SZ-1:0]   sb_txid_q, sb_txid_d;
  logic [ASZ-1:0]       sb_itemid_q, sb_itemid_d;
  logic [WIDTH-1:0]     sb_mask_q, sb_mask_d;
  logic [WIDTH-1:0]     sb_data_q, sb_data_d;
  logic                 p_srdy_q, p_srdy_d;
  logic [ASZ-1:0]       p_itemid_q, p_itemid_d;
  logic [WIDTH-1:0]     p_old_q, p_old_d;
  logic [WIDTH-1:0]     p_new_q, p_new_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     alu_new, alu_mask;
  logic                 rsp_match;

  sd_scoreboard_rmw_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i      (op_q),
    .old_i     (sbr_data_i),
    .operand_i (operand_q),
    .new_o     (alu_new),
    .mask_o    (alu_mask)
  );

  // sb_txid_q keeps the id of the read in flight, so it doubles as the expected response id.
  assign rsp_match = (state_q == ST_RDWAIT) && sbr_srdy_i && (sbr_txid_i == sb_txid_q);

  always_comb begin
    state_d       = state_q;
    cur_txid_d    = cur_txid_q;
    op_d          = op_q;
    operand_d     = operand_q;
    sb_srdy_d     = sb_srdy_q;
    sb_req_type_d = sb_req_type_q;
    sb_txid_d     = sb_txid_q;
    sb_itemid_d   = sb_itemid_q;
    sb_mask_d     = sb_mask_q;
    sb_data_d     = sb_data_q;
    p_srdy_d      = p_srdy_q;
    p_itemid_d    = p_itemid_q;
    p_old_d       = p_old_q;
    p_new_d       = p_new_q;
    err_d         = sbr_srdy_i && !rsp_match;
    case (state_q)
      ST_IDLE: begin
        if (c_srdy_i) begin
          op_d          = c_op_i;
          operand_d     = c_operand_i;
          sb_srdy_d     = 1'b1;
          sb_req_type_d = REQ_READ;
          sb_txid_d     = cur_txid_q;
          sb_itemid_d   = c_itemid_i;
          state_d       = ST_RDREQ;
        end
      end
      ST_RDREQ: begin
        if (sb_drdy_i) begin
          sb_srdy_d  = 1'b0;
          cur_txid_d = cur_txid_q + TXID_SZ'(1);
          state_d    = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if (rsp_match) begin
          p_itemid_d = sb_itemid_q;
          p_old_d    = sbr_data_i;
          p_new_d    = alu_new;
          sb_data_d  = alu_new;
          sb_mask_d  = alu_mask;
          if (op_q == OP_READ) begin
            p_srdy_d = 1'b1;
            state_d  = ST_RESULT;
          end else begin
            sb_srdy_d     = 1'b1;
            sb_req_type_d = REQ_WRITE;
            state_d       = ST_WRREQ;
          end
        end
      end
      ST_WRREQ: begin
        if (sb_drdy_i) begin
          sb_srdy_d = 1'b0;
          p_srdy_d  = 1'b1;
          state_d   = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (p_drdy_i) begin
          p_srdy_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_txid_q    <= '0;
      op_q          <= '0;
      operand_q     <= '0;
      sb_srdy_q     <= 1'b0;
      sb_req_type_q <= 1'b0;
      sb_txid_q     <= '0;
      sb_itemid_q   <= '0;
      sb_mask_q     <= '0;
      sb_data_q     <= '0;
      p_srdy_q      <= 1'b0;
      p_itemid_q    <= '0;
      p_old_q       <= '0;
      p_new_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_txid_q    <= cur_txid_d;
      op_q          <= op_d;
      operand_q     <= operand_d;
      sb_srdy_q     <= sb_srdy_d;
      sb_req_type_q <= sb_req_type_d;
      sb_txid_q     <= sb_txid_d;
      sb_itemid_q   <= sb_itemid_d;
      sb_mask_q     <= sb_mask_d;
      sb_data_q     <= sb_data_d;
      p_srdy_q      <= p_srdy_d;
      p_itemid_q    <= p_itemid_d;
      p_old_q       <= p_old_d;
      p_new_q       <= p_new_d;
      err_q         <= err_d;
    end
  end

  assign c_drdy_o      = (state_q == ST_IDLE);
  assign sbr_drdy_o    = 1'b1;
  assign sb_srdy_o     = sb_srdy_q;
  assign sb_req_type_o = sb_req_type_q;
  assign sb_txid_o     = sb_txid_q;
  assign sb_itemid_o   = sb_itemid_q;
  assign sb_mask_o     = sb_mask_q;
  assign sb_data_o     = sb_data_q;
  assign p_srdy_o      = p_srdy_q;
  assign p_itemid_o    = p_itemid_q;
  assign p_old_o       = p_old_q;
  assign p_new_o       = p_new_q;
  assign err_txid_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_scoreboard_rmw.sv
// Self-checking bench for sd_scoreboard_rmw with a scoreboard responder and a result model.
`timescale 1ns/1ps
`default_nettype none

module tb_sd_scoreboard_rmw;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c_srdy_i = 1'b0;
  logic       c_drdy_o;
  logic [1:0] c_op_i = '0;
  logic [5:0] c_itemid_i = '0;
  logic [7:0] c_operand_i = '0;
  logic       sb_srdy_o;
  logic       sb_drdy_i = 1'b1;
  logic       sb_req_type_o;
  logic [1:0] sb_txid_o;
  logic [5:0] sb_itemid_o;
  logic [7:0] sb_mask_o;
  logic [7:0] sb_data_o;
  logic       sbr_srdy_i = 1'b0;
  logic       sbr_drdy_o;
  logic [1:0] sbr_txid_i = '0;
  logic [7:0] sbr_data_i = '0;
  logic       p_srdy_o;
  logic       p_drdy_i = 1'b1;
  logic [5:0] p_itemid_o;
  logic [7:0] p_old_o;
  logic [7:0] p_new_o;
  logic       err_txid_o;

  always #5 clk = ~clk;

  sd_scoreboard_rmw #(.WIDTH(8), .ASZ(6), .TXID_SZ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_srdy_i(c_srdy_i), .c_drdy_o(c_drdy_o), .c_op_i(c_op_i),
    .c_itemid_i(c_itemid_i), .c_operand_i(c_operand_i),
    .sb_srdy_o(sb_srdy_o), .sb_drdy_i(sb_drdy_i), .sb_req_type_o(sb_req_type_o),
    .sb_txid_o(sb_txid_o), .sb_itemid_o(sb_itemid_o), .sb_mask_o(sb_mask_o),
    .sb_data_o(sb_data_o),
    .sbr_srdy_i(sbr_srdy_i), .sbr_drdy_o(sbr_drdy_o), .sbr_txid_i(sbr_txid_i),
    .sbr_data_i(sbr_data_i),
    .p_srdy_o(p_srdy_o), .p_drdy_i(p_drdy_i), .p_itemid_o(p_itemid_o),
    .p_old_o(p_old_o), .p_new_o(p_new_o), .err_txid_o(err_txid_o)
  );

  typedef struct { logic [5:0] item; logic [7:0] old_v; logic [7:0] new_v; } res_t;
  typedef struct { logic [5:0] item; logic [7:0] data; logic [7:0] mask; } wr_t;
  typedef struct { int due; logic [1:0] txid; logic [7:0] data; } rsp_t;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [64];
  logic [7:0] shadow [64];
  res_t exp_res [$];
  wr_t  exp_wr [$];
  rsp_t rq [$];
  rsp_t r;
  res_t e_res, last_p;
  wr_t  e_wr, last_wr;

  bit   busy = 0;
  int   exp_txid = 0;
  int   exp_err = 0;
  int   err_seen = 0;
  int   n_wr_seen = 0;
  bit   rd_hs = 0;
  logic [1:0] rd_txid;
  logic [5:0] rd_item;
  logic [1:0] last_rd_txid = '0;
  bit   inject_bad = 0;
  bit   stray = 0;
  int   ncyc = 0;
  int   acc_cyc = 0;
  int   exp_lat = 0;
  int   rcyc = 0;

  bit          prev_sb_hold = 0, prev_p_hold = 0, prev_p_srdy = 0;
  logic [25:0] prev_sb_vec;
  logic [22:0] prev_p_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [7:0] model_new(input int op, input logic [7:0] old_v,
                                           input logic [7:0] opnd);
    int s;
    case (op)
      1: begin s = (int'(old_v) + int'(opnd)) % 256; return 8'(s); end
      2: return old_v | opnd;
      3: return old_v & ~opnd;
      default: return old_v;
    endcase
  endfunction

  // Scoreboard responder: answers each accepted read one cycle after the request is taken.
  always begin
    @(posedge clk); #1;
    rcyc++;
    sbr_srdy_i = 1'b0;
    if (!rst_n) begin
      rq.delete();
      rd_hs = 0;
    end else begin
      if (rd_hs) begin
        rd_hs = 0;
        if (inject_bad) begin
          rq.push_back('{rcyc + 1, 2'd3, 8'h55});
          rq.push_back('{rcyc + 2, rd_txid, mem[rd_item]});
          inject_bad = 0;
          exp_err++;
        end else begin
          rq.push_back('{rcyc + 1, rd_txid, mem[rd_item]});
        end
      end
      if (rq.size() > 0 && rq[0].due == rcyc) begin
        r = rq.pop_front();
        sbr_srdy_i = 1'b1;
        sbr_txid_i = r.txid;
        sbr_data_i = r.data;
      end else if (stray) begin
        stray = 0;
        sbr_srdy_i = 1'b1;
        sbr_txid_i = 2'd1;
        sbr_data_i = 8'hEE;
        exp_err++;
      end
    end
  end

  // Compare process: every mid-cycle, checks the DUT against the model state.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sb_hold = 0;
      prev_p_hold  = 0;
      prev_p_srdy  = 0;
      exp_res.delete();
      exp_wr.delete();
      busy     = 0;
      exp_txid = 0;
    end else begin
      ncyc++;
      chk("c_drdy", {31'd0, c_drdy_o}, {31'd0, !busy});
      if (prev_sb_hold)
        chk("sb_stable", {6'd0, sb_srdy_o, sb_req_type_o, sb_txid_o, sb_itemid_o, sb_mask_o, sb_data_o},
            {6'd0, prev_sb_vec});
      if (prev_p_hold)
        chk("p_stable", {9'd0, p_srdy_o, p_itemid_o, p_old_o, p_new_o}, {9'd0, prev_p_vec});
      if (err_txid_o) err_seen++;
      if (c_srdy_i && c_drdy_o) begin
        busy    = 1;
        acc_cyc = ncyc;
      end
      if (sb_srdy_o && sb_drdy_i) begin
        if (!sb_req_type_o) begin
          chk("rd_txid", {30'd0, sb_txid_o}, exp_txid);
          exp_txid = (exp_txid + 1) % 4;
          if (exp_res.size() > 0) chk("rd_item", {26'd0, sb_itemid_o}, {26'd0, exp_res[0].item});
          else fail_now("rd_unexpected", $sformatf("got read of item 0x%0h, required none", sb_itemid_o));
          rd_hs = 1;
          rd_txid = sb_txid_o;
          rd_item = sb_itemid_o;
          last_rd_txid = sb_txid_o;
        end else begin
          n_wr_seen++;
          if (exp_wr.size() > 0) begin
            e_wr = exp_wr.pop_front();
            chk("wr_item", {26'd0, sb_itemid_o}, {26'd0, e_wr.item});
            chk("wr_data", {24'd0, sb_data_o}, {24'd0, e_wr.data});
            chk("wr_mask", {24'd0, sb_mask_o}, {24'd0, e_wr.mask});
          end else begin
            fail_now("wr_unexpected", $sformatf("got write item 0x%0h data 0x%0h, required none",
                                                sb_itemid_o, sb_data_o));
          end
          last_wr = '{sb_itemid_o, sb_data_o, sb_mask_o};
          mem[sb_itemid_o] = (mem[sb_itemid_o] & ~sb_mask_o) | (sb_data_o & sb_mask_o);
        end
      end
      if (p_srdy_o && !prev_p_srdy && exp_lat > 0)
        chk("latency", ncyc - acc_cyc, exp_lat);
      if (p_srdy_o && p_drdy_i) begin
        if (exp_res.size() > 0) begin
          e_res = exp_res.pop_front();
          chk("p_itemid", {26'd0, p_itemid_o}, {26'd0, e_res.item});
          chk("p_old", {24'd0, p_old_o}, {24'd0, e_res.old_v});
          chk("p_new", {24'd0, p_new_o}, {24'd0, e_res.new_v});
        end else begin
          fail_now("p_unexpected", $sformatf("got result item 0x%0h, required none", p_itemid_o));
        end
        last_p = '{p_itemid_o, p_old_o, p_new_o};
        busy = 0;
      end
      prev_sb_hold = sb_srdy_o && !sb_drdy_i;
      prev_sb_vec  = {sb_srdy_o, sb_req_type_o, sb_txid_o, sb_itemid_o, sb_mask_o, sb_data_o};
      prev_p_hold  = p_srdy_o && !p_drdy_i;
      prev_p_vec   = {p_srdy_o, p_itemid_o, p_old_o, p_new_o};
      prev_p_srdy  = p_srdy_o;
    end
  end

  task automatic preload(input int item, input logic [7:0] v);
    mem[item] = v;
    shadow[item] = v;
  endtask

  task automatic wait_for(input int sel, input string name);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = c_drdy_o;
        1: hit = sb_srdy_o && !sb_req_type_o;
        2: hit = sb_srdy_o && sb_req_type_o;
        default: hit = p_srdy_o;
      endcase
    end
    if (!hit) fail_now(name, "no handshake within 60 cycles");
  endtask

  task automatic pulse_sb_drdy();
    @(posedge clk); #1 sb_drdy_i = 1'b1;
    @(posedge clk); #1 sb_drdy_i = 1'b0;
  endtask

  task automatic expect_cmd(input int op, input int item, input logic [7:0] opnd);
    logic [7:0] o, n;
    o = shadow[item];
    n = model_new(op, o, opnd);
    exp_res.push_back('{6'(item), o, n});
    if (op != 0) exp_wr.push_back('{6'(item), n, (op == 1) ? 8'hFF : opnd});
    shadow[item] = n;
  endtask

  task automatic send_cmd(input int op, input int item, input logic [7:0] opnd);
    c_op_i = 2'(op);
    c_itemid_i = 6'(item);
    c_operand_i = opnd;
    c_srdy_i = 1'b1;
    wait_for(0, "c_accept");
    @(posedge clk); #1 c_srdy_i = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int item, input logic [7:0] opnd, input bit stall);
    expect_cmd(op, item, opnd);
    exp_lat = (stall || inject_bad) ? 0 : ((op == 0) ? 4 : 5);
    sb_drdy_i = !stall;
    p_drdy_i = !stall;
    send_cmd(op, item, opnd);
    if (stall) begin
      wait_for(1, "rd_req");
      repeat (10) @(negedge clk);
      pulse_sb_drdy();
      if (op != 0) begin
        wait_for(2, "wr_req");
        repeat (10) @(negedge clk);
        pulse_sb_drdy();
      end
      wait_for(3, "result");
      repeat (10) @(negedge clk);
      @(posedge clk); #1 p_drdy_i = 1'b1;
      @(posedge clk); #1 p_drdy_i = 1'b0;
    end else begin
      wait_for(3, "result");
      @(posedge clk); #1;
    end
    exp_lat = 0;
  endtask

  initial begin
    int ids [5];
    int e0, wr0;
    ids = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 64; i++) preload(i, 8'(i));
    preload(5, 8'h3C);
    preload(2, 8'hFE);
    preload(9, 8'hA0);
    preload(7, 8'h10);
    preload(10, 8'h90);
    preload(20, 8'h40);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_sb_srdy", {31'd0, sb_srdy_o}, 0);
    chk("rst_p_srdy", {31'd0, p_srdy_o}, 0);
    chk("rst_c_drdy", {31'd0, c_drdy_o}, 1);
    chk("rst_outs", {sb_txid_o, sb_itemid_o, sb_data_o, p_old_o, p_new_o, err_txid_o}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // READ item 5
    run_cmd(0, 5, 8'h00, 0);
    chk("t1_item", {26'd0, last_p.item}, 5);
    chk("t1_old", {24'd0, last_p.old_v}, 32'h3C);
    chk("t1_new", {24'd0, last_p.new_v}, 32'h3C);
    chk("t1_no_write", n_wr_seen, 0);

    // ADD wraps past 0xFF
    run_cmd(1, 2, 8'h05, 0);
    chk("t2_txid", {30'd0, last_rd_txid}, 1);
    chk("t2_wdata", {24'd0, last_wr.data}, 32'h03);
    chk("t2_wmask", {24'd0, last_wr.mask}, 32'hFF);
    chk("t2_old", {24'd0, last_p.old_v}, 32'hFE);
    chk("t2_new", {24'd0, last_p.new_v}, 32'h03);

    run_cmd(2, 9, 8'h0F, 0);
    chk("t3_set_data", {24'd0, last_wr.data}, 32'hAF);
    chk("t3_set_mask", {24'd0, last_wr.mask}, 32'h0F);
    run_cmd(3, 9, 8'h81, 0);
    chk("t3_clr_data", {24'd0, last_wr.data}, 32'h2E);
    chk("t3_clr_mask", {24'd0, last_wr.mask}, 32'h81);
    chk("t3_new", {24'd0, last_p.new_v}, 32'h2E);

    // Mismatched txid while waiting, then a stray response while idle
    e0 = err_seen;
    inject_bad = 1;
    run_cmd(1, 7, 8'h22, 0);
    chk("t4_err_pulses", err_seen - e0, 1);
    chk("t4_new", {24'd0, last_p.new_v}, 32'h32);
    e0 = err_seen;
    stray = 1;
    repeat (4) @(posedge clk); #1;
    chk("t4_stray_err", err_seen - e0, 1);

    // Backpressure on every handshake; txid wraps 3 -> 0 on the fourth command
    for (int i = 0; i < 5; i++) begin
      run_cmd((i == 3) ? 0 : ((i % 3) + 1), 10 + i, 8'h80 | 8'(i), 1);
      chk("t5_txid", {30'd0, last_rd_txid}, ids[i]);
    end
    chk("t5_mem10", {24'd0, mem[10]}, 32'h10);
    sb_drdy_i = 1'b1;
    p_drdy_i = 1'b1;

    // Reset while a write is pending
    wr0 = n_wr_seen;
    expect_cmd(1, 20, 8'h01);
    sb_drdy_i = 1'b0;
    send_cmd(1, 20, 8'h01);
    wait_for(1, "t6_rd_req");
    pulse_sb_drdy();
    wait_for(2, "t6_wr_req");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_sb_srdy", {31'd0, sb_srdy_o}, 0);
    chk("t6_sb_outs", {sb_req_type_o, sb_txid_o, sb_mask_o, sb_data_o}, 0);
    chk("t6_c_drdy", {31'd0, c_drdy_o}, 1);
    shadow[20] = 8'h40;
    @(posedge clk); #1 rst_n = 1'b1;
    sb_drdy_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t6_no_write", n_wr_seen - wr0, 0);
    chk("t6_mem", {24'd0, mem[20]}, 32'h40);
    run_cmd(0, 20, 8'h00, 0);
    chk("t6_txid", {30'd0, last_rd_txid}, 0);
    chk("t6_old", {24'd0, last_p.old_v}, 32'h40);

    repeat (3) @(posedge clk); #1;
    chk("end_res_q", exp_res.size(), 0);
    chk("end_wr_q", exp_wr.size(), 0);
    chk("end_err", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
